// File: rtl/row_enc_pkg.sv
// Shared types, constants and the row-to-code mapping for the row line encoder.
package row_enc_pkg;

    localparam int unsigned ROW_W  = 7;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CODE_W-1:0] NO_ROW_CODE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD,
        WAIT_RELEASE
    } state_e;

    // Ln (bit n-1) encodes to 7-n; anything that is not exactly one row maps to NO_ROW_CODE
    function automatic logic [CODE_W-1:0] row_to_code(input logic [ROW_W-1:0] pat);
        logic [CODE_W-1:0] code;
        case (pat)
            7'b0000001: code = 3'b110;
            7'b0000010: code = 3'b101;
            7'b0000100: code = 3'b100;
            7'b0001000: code = 3'b011;
            7'b0010000: code = 3'b010;
            7'b0100000: code = 3'b001;
            7'b1000000: code = 3'b000;
            default:    code = NO_ROW_CODE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/row_onehot_check.sv
// Combinational classifier for a 7-bit row pattern: zero / one-hot / multi-hot, plus its row code.
module row_onehot_check
    import row_enc_pkg::*;
(
    input  logic [6:0] pat,
    output logic       is_zero,
    output logic       is_onehot,
    output logic [2:0] code
);

    // Clearing the lowest set bit leaves zero only for a single-bit pattern
    always_comb begin
        is_zero   = (pat == 7'd0);
        is_onehot = !is_zero && ((pat & (pat - 7'd1)) == 7'd0);
        code      = row_to_code(pat);
    end

endmodule

// File: rtl/row_line_encoder.sv
// Debouncing row-line encoder: accepts a stable one-hot row pattern and offers its
// 3-bit code over valid/ready. Multi-hot stable patterns raise err.
// Optional build macro ROW_ENC_STICKY_ERR_EN: err holds at 1 until rst instead of pulsing.
module row_line_encoder
    import row_enc_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] l_in,
    output logic [2:0] out_abc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [ROW_W-1:0]  s_reg_q, s_reg_d;
    logic [ROW_W-1:0]  cap_q, cap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] abc_q, abc_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              err_pulse;

    logic              s_zero;
    logic              s_onehot;
    logic [CODE_W-1:0] s_code;

    row_onehot_check u_check (
        .pat       (s_reg_q),
        .is_zero   (s_zero),
        .is_onehot (s_onehot),
        .code      (s_code)
    );

    // Next-state, capture/count and registered-output decisions
    always_comb begin
        s_reg_d   = l_in;
        state_d   = state_q;
        cap_d     = cap_q;
        cnt_d     = cnt_q;
        abc_d     = abc_q;
        err_pulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s_zero) begin
                    cap_d   = s_reg_q;
                    cnt_d   = CNT_W'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (s_reg_q == cap_q) begin
                    if (cnt_q == CNT_LAST) begin
                        if (s_onehot) begin
                            abc_d   = s_code;
                            state_d = HOLD;
                        end else begin
                            err_pulse = 1'b1;
                            state_d   = WAIT_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (s_zero) begin
                    state_d = IDLE;
                end else begin
                    cap_d = s_reg_q;
                    cnt_d = CNT_W'(1);
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (s_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Code is frozen while holding; every other state shows "no row"
        if (state_d != HOLD) begin
            abc_d = NO_ROW_CODE;
        end
        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);

`ifdef ROW_ENC_STICKY_ERR_EN
        err_d = err_q | err_pulse;
`else
        err_d = err_pulse;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg_q <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            abc_q   <= NO_ROW_CODE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s_reg_q <= s_reg_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            abc_q   <= abc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign out_abc   = abc_q;
    assign out_valid = valid_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_row_line_encoder.sv
// Bench for row_line_encoder: run-length behavioural model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_row_line_encoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] l_in;
    logic [2:0] out_abc;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    row_line_encoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .l_in      (l_in),
        .out_abc   (out_abc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: a row is accepted after STABLE identical non-zero samples; then it is
    // offered until taken, and nothing new is considered until the lines go all-zero.
    logic [6:0] m_s;
    logic [6:0] m_pat;
    int         m_run;
    bit         m_pend;
    bit         m_lock;
    bit         m_err;
    logic [2:0] m_code;

    function automatic logic [2:0] model_code(input logic [6:0] p);
        logic [2:0] c = 3'b111;
        for (int i = 0; i < 7; i++) begin
            if (p[i]) c = 3'(6 - i);
        end
        return c;
    endfunction

    always @(posedge clk) begin
        bit pulse;
        pulse = 1'b0;
        if (rst) begin
            m_s = '0; m_pat = '0; m_run = 0;
            m_pend = 1'b0; m_lock = 1'b0; m_err = 1'b0; m_code = 3'b111;
        end else begin
            if (m_pend) begin
                if (out_ready) begin
                    m_pend = 1'b0;
                    m_lock = 1'b1;
                end
            end else if (m_lock) begin
                if (m_s == 7'd0) m_lock = 1'b0;
            end else if (m_s == 7'd0) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && m_s == m_pat) begin
                    m_run++;
                end else begin
                    m_run = 1;
                    m_pat = m_s;
                end
                if (m_run == STABLE) begin
                    m_run = 0;
                    if ($countones(m_pat) == 1) begin
                        m_pend = 1'b1;
                        m_code = model_code(m_pat);
                    end else begin
                        m_lock = 1'b1;
                        pulse  = 1'b1;
                    end
                end
            end
`ifdef ROW_ENC_STICKY_ERR_EN
            m_err = m_err | pulse;
`else
            m_err = pulse;
`endif
            m_s = l_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", 32'(out_valid), 32'(m_pend));
            chk("m_abc",   32'(out_abc),   32'(m_pend ? m_code : 3'b111));
            chk("m_err",   32'(err),       32'(m_err));
            chk("m_busy",  32'(busy),      32'(m_run > 0 || m_pend || m_lock));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean row with out_ready high: valid for exactly one cycle, STABLE+1 edges after apply
    task automatic run_row(input logic [6:0] pat, input logic [2:0] exp_code);
        l_in = pat;
        tick(STABLE);
        chk("row_early_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("row_valid", 32'(out_valid), 32'd1);
        chk("row_abc",   32'(out_abc),   32'(exp_code));
        tick(1);
        chk("row_taken_valid", 32'(out_valid), 32'd0);
        chk("row_taken_abc",   32'(out_abc),   32'h7);
        l_in = 7'd0;
        tick(3);
        chk("row_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int err_cnt;
        bit saw_valid;
        bit saw_any;

        rst       = 1'b1;
        l_in      = 7'b0000001;
        out_ready = 1'b1;
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        chk("rst_abc",   32'(out_abc),   32'h7);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;

        run_row(7'b0000001, 3'b110);
        run_row(7'b1000000, 3'b000);
        run_row(7'b0001000, 3'b011);

        // Backpressure: code stays frozen even though the lines move to L5
        out_ready = 1'b0;
        l_in = 7'b0000010;
        tick(STABLE + 1);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_abc",   32'(out_abc),   32'h5);
        l_in = 7'b0010000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_abc",   32'(out_abc),   32'h5);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        chk("bp_wait_busy", 32'(busy),     32'd1);
        tick(2);
        chk("bp_no_reaccept", 32'(out_valid), 32'd0);
        l_in = 7'd0;
        tick(3);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Glitch shorter than the debounce window
        saw_any = 1'b0;
        l_in = 7'b0000100;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (out_valid || err) saw_any = 1'b1;
        end
        l_in = 7'd0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (out_valid || err) saw_any = 1'b1;
        end
        chk("glitch_quiet", 32'(saw_any), 32'd0);
        chk("glitch_busy",  32'(busy),    32'd0);

        // Multi-hot: err, never valid, busy until release
        err_cnt   = 0;
        saw_valid = 1'b0;
        l_in = 7'b0000011;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (err) err_cnt++;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mh_busy_held", 32'(busy), 32'd1);
        l_in = 7'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (err) err_cnt++;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mh_no_valid", 32'(saw_valid), 32'd0);
        chk("mh_busy_rel", 32'(busy),      32'd0);
`ifdef ROW_ENC_STICKY_ERR_EN
        chk("mh_err_sticky", 32'(err), 32'd1);
`else
        chk("mh_err_pulses", 32'(err_cnt), 32'd1);
`endif

        // Reset while holding drops the code; L6 is then re-accepted after full latency
        out_ready = 1'b0;
        l_in = 7'b0100000;
        tick(STABLE + 1);
        chk("rh_valid", 32'(out_valid), 32'd1);
        chk("rh_abc",   32'(out_abc),   32'h1);
        rst = 1'b1;
        tick(1);
        chk("rh_rst_valid", 32'(out_valid), 32'd0);
        chk("rh_rst_abc",   32'(out_abc),   32'h7);
        chk("rh_rst_err",   32'(err),       32'd0);
        rst = 1'b0;
        tick(STABLE);
        chk("rh_early_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("rh_again_valid", 32'(out_valid), 32'd1);
        chk("rh_again_abc",   32'(out_abc),   32'h1);
        out_ready = 1'b1;
        tick(1);
        chk("rh_hs_valid", 32'(out_valid), 32'd0);
        l_in = 7'd0;
        tick(3);
        chk("rh_idle_busy", 32'(busy), 32'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
